// File: rtl/window_buffer_kxk_pkg.sv
// Shared types and index helpers for the WIN x WIN sliding window buffer.
package window_pkg;

    // Direction the window moves over the image.
    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_UP    = 2'b11
    } shift_dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        READY = 2'b10,
        LOAD  = 2'b11
    } wb_state_t;

    // Element index written by the cnt-th accepted pixel. A full fill runs
    // in raster order; a line load targets the line vacated by the slide.
    function automatic int wr_index(shift_dir_t dir, int cnt, int win, logic is_fill);
        int idx;
        idx = cnt;
        if (!is_fill) begin
            case (dir)
                DIR_RIGHT: idx = cnt * win + (win - 1);
                DIR_LEFT:  idx = cnt * win;
                DIR_DOWN:  idx = (win - 1) * win + cnt;
                default:   idx = cnt;
            endcase
        end
        return idx;
    endfunction

    // Source element feeding element (r, c) during a slide; -1 marks the
    // vacated line, which is cleared.
    function automatic int slide_src(shift_dir_t dir, int r, int c, int win);
        int src;
        src = -1;
        case (dir)
            DIR_RIGHT: if (c < win - 1) src = r * win + c + 1;
            DIR_LEFT:  if (c > 0)       src = r * win + c - 1;
            DIR_DOWN:  if (r < win - 1) src = (r + 1) * win + c;
            default:   if (r > 0)       src = (r - 1) * win + c;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/window_buffer_kxk_if.sv
// Command, pixel stream and window result bundle of the window buffer.
interface window_buffer_kxk_if #(
    parameter int PIX_W = 8,
    parameter int WIN   = 3,
    parameter int CNT_W = $clog2(WIN * WIN + 1)
) ();
    import window_pkg::*;

    logic                       start_fill;
    logic                       start_shift;
    shift_dir_t                 shift_dir;
    logic                       abort;
    logic [PIX_W-1:0]           pix_in;
    logic                       pix_valid;
    logic                       pix_ready;
    logic [WIN*WIN*PIX_W-1:0]   win_out;
    logic                       win_valid;
    logic                       fill_done;
    logic                       shift_done;
    logic                       cmd_err;
    logic [CNT_W-1:0]           count;

    modport master (
        output start_fill, start_shift, shift_dir, abort, pix_in, pix_valid,
        input  pix_ready, win_out, win_valid, fill_done, shift_done, cmd_err, count
    );

    modport slave (
        input  start_fill, start_shift, shift_dir, abort, pix_in, pix_valid,
        output pix_ready, win_out, win_valid, fill_done, shift_done, cmd_err, count
    );

endinterface

// File: rtl/window_buffer_kxk_line_index.sv
// Maps the latched direction and accept count to the element being written.
module wb_line_index
    import window_pkg::*;
#(
    parameter int WIN   = 3,
    parameter int CNT_W = $clog2(WIN * WIN + 1),
    parameter int IDX_W = $clog2(WIN * WIN)
) (
    input  shift_dir_t       i_dir,
    input  logic [CNT_W-1:0] i_count,
    input  logic             i_is_fill,
    output logic [IDX_W-1:0] o_idx
);

    // Pure index arithmetic, no state.
    always_comb begin
        o_idx = IDX_W'(wr_index(i_dir, int'(i_count), WIN, i_is_fill));
    end

endmodule

// File: rtl/window_buffer_kxk.sv
// WIN x WIN pixel window: full raster fill, one-step slide plus line reload.
module window_buffer_kxk
    import window_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int WIN   = 3,
    parameter int CNT_W = $clog2(WIN * WIN + 1)
) (
    input logic               clk,
    input logic               rst,
    window_buffer_kxk_if.slave bus
);

    localparam int N     = WIN * WIN;
    localparam int IDX_W = $clog2(N);

    wb_state_t        r_state;
    wb_state_t        w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    shift_dir_t       r_dir;
    logic [PIX_W-1:0] r_win      [N];
    logic [PIX_W-1:0] w_win_next [N];
    logic             r_fill_done;
    logic             r_shift_done;
    logic             r_cmd_err;
    logic             w_fill_done;
    logic             w_shift_done;
    logic             w_cmd_err;
    logic             w_slide;
    logic             w_pix_ready;
    logic             w_accept;
    logic [IDX_W-1:0] w_wr_idx;
    int               w_src;

    // An abort wins over a pixel offered in the same cycle.
    assign w_pix_ready = (r_state == FILL) || (r_state == LOAD);
    assign w_accept    = bus.pix_valid && w_pix_ready && !bus.abort;

    wb_line_index #(
        .WIN   (WIN),
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_line_index (
        .i_dir     (r_dir),
        .i_count   (r_count),
        .i_is_fill (r_state == FILL),
        .o_idx     (w_wr_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next state, accept counter and completion/error pulses.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_next_state = r_state;
        w_count_next = r_count;
        w_cmd_err    = 1'b0;
        w_fill_done  = 1'b0;
        w_shift_done = 1'b0;
        w_slide      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start_fill) begin
                    w_next_state = FILL;
                    w_count_next = '0;
                end else if (bus.start_shift) begin
                    w_cmd_err = 1'b1;
                end
            end
            FILL: begin
                w_cmd_err = bus.start_fill || bus.start_shift;
                if (bus.abort) begin
                    w_next_state = IDLE;
                    w_count_next = '0;
                end else if (w_accept) begin
                    if (r_count != CNT_W'(N)) w_count_next = r_count + 1'b1;
                    if (r_count == CNT_W'(N - 1)) begin
                        w_next_state = READY;
                        w_fill_done  = 1'b1;
                    end
                end
            end
            READY: begin
                if (bus.start_fill) begin
                    w_next_state = FILL;
                    w_count_next = '0;
                end else if (bus.start_shift) begin
                    w_next_state = LOAD;
                    w_count_next = '0;
                    w_slide      = 1'b1;
                end
            end
            LOAD: begin
                w_cmd_err = bus.start_fill || bus.start_shift;
                if (bus.abort) begin
                    w_next_state = IDLE;
                    w_count_next = '0;
                end else if (w_accept) begin
                    if (r_count != CNT_W'(WIN)) w_count_next = r_count + 1'b1;
                    if (r_count == CNT_W'(WIN - 1)) begin
                        w_next_state = READY;
                        w_shift_done = 1'b1;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Counter, latched slide direction and registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count      <= '0;
            r_dir        <= DIR_RIGHT;
            r_fill_done  <= 1'b0;
            r_shift_done <= 1'b0;
            r_cmd_err    <= 1'b0;
        end else begin
            r_count      <= w_count_next;
            r_fill_done  <= w_fill_done;
            r_shift_done <= w_shift_done;
            r_cmd_err    <= w_cmd_err;
            if (w_slide) r_dir <= bus.shift_dir;
        end
    end

    // Next window: whole-window slide on a shift command, else one pixel write.
    always_comb begin
        w_win_next = r_win;
        w_src      = 0;
        if (w_slide) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN; c++) begin
                    w_src = slide_src(bus.shift_dir, r, c, WIN);
                    w_win_next[IDX_W'(r * WIN + c)] = (w_src < 0) ? '0 : r_win[IDX_W'(w_src)];
                end
            end
        end else if (w_accept) begin
            w_win_next[w_wr_idx] = bus.pix_in;
        end
    end

    // Window register array.
    always_ff @(posedge clk) begin
        // NOTE: the window array is reset because a cleared window is observable state.
        if (rst) begin
            for (int i = 0; i < N; i++) r_win[i] <= '0;
        end else begin
            r_win <= w_win_next;
        end
    end

    // Flatten the window for the convolution datapath.
    always_comb begin
        bus.win_out = '0;
        for (int i = 0; i < N; i++) bus.win_out[i*PIX_W +: PIX_W] = r_win[i];
    end

    assign bus.pix_ready  = w_pix_ready;
    assign bus.win_valid  = (r_state == READY);
    assign bus.fill_done  = r_fill_done;
    assign bus.shift_done = r_shift_done;
    assign bus.cmd_err    = r_cmd_err;
    assign bus.count      = r_count;

endmodule

// File: tb/tb_window_buffer_kxk.sv
// Directed bench for window_buffer_kxk with WIN=3, PIX_W=8.
module tb_window_buffer_kxk;
    import window_pkg::*;

    localparam int PIX_W = 8;
    localparam int WIN   = 3;
    localparam int N     = WIN * WIN;
    localparam int CNT_W = $clog2(N + 1);
    localparam int WW    = N * PIX_W;

    typedef logic [PIX_W-1:0] pix_arr_t [N];

    logic clk;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    window_buffer_kxk_if #(.PIX_W(PIX_W), .WIN(WIN), .CNT_W(CNT_W)) bus ();

    window_buffer_kxk #(.PIX_W(PIX_W), .WIN(WIN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    function automatic logic [WW-1:0] pack_win(input pix_arr_t e);
        logic [WW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*PIX_W +: PIX_W] = e[i];
        return v;
    endfunction

    task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [PIX_W-1:0] p);
        bus.pix_valid = 1'b1;
        bus.pix_in    = p;
        tick();
        bus.pix_valid = 1'b0;
    endtask

    task automatic fill_window(input int base);
        bus.start_fill = 1'b1;
        tick();
        bus.start_fill = 1'b0;
        for (int i = 0; i < N; i++) send_pixel(PIX_W'(base + i));
    endtask

    task automatic do_shift(input shift_dir_t d, input logic [PIX_W-1:0] p0,
                            input logic [PIX_W-1:0] p1, input logic [PIX_W-1:0] p2);
        bus.shift_dir   = d;
        bus.start_shift = 1'b1;
        tick();
        bus.start_shift = 1'b0;
        send_pixel(p0);
        send_pixel(p1);
        send_pixel(p2);
    endtask

    initial begin
        rst             = 1'b1;
        bus.start_fill  = 1'b0;
        bus.start_shift = 1'b0;
        bus.shift_dir   = DIR_RIGHT;
        bus.abort       = 1'b0;
        bus.pix_in      = '0;
        bus.pix_valid   = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("rst_win", bus.win_out, '0);
        check("rst_win_valid", bus.win_valid, 1'b0);
        check("rst_count", bus.count, 0);
        check("rst_pix_ready", bus.pix_ready, 1'b0);
        check("rst_pulses", {bus.fill_done, bus.shift_done, bus.cmd_err}, 3'b000);

        // Test 1: back-to-back fill with 0..8.
        bus.start_fill = 1'b1;
        tick();
        bus.start_fill = 1'b0;
        check("t1_pix_ready", bus.pix_ready, 1'b1);
        check("t1_count0", bus.count, 0);
        for (int i = 0; i < N - 1; i++) send_pixel(PIX_W'(i));
        check("t1_count8", bus.count, 8);
        check("t1_no_done_early", bus.fill_done, 1'b0);
        check("t1_no_valid_early", bus.win_valid, 1'b0);
        send_pixel(8'd8);
        check("t1_fill_done", bus.fill_done, 1'b1);
        check("t1_win_valid", bus.win_valid, 1'b1);
        check("t1_count9", bus.count, 9);
        check("t1_ready_low", bus.pix_ready, 1'b0);
        check("t1_window", bus.win_out, pack_win('{0, 1, 2, 3, 4, 5, 6, 7, 8}));
        tick();
        check("t1_done_pulse", bus.fill_done, 1'b0);
        check("t1_valid_held", bus.win_valid, 1'b1);

        // Test 2: slide right, reload column 2; direction changes mid-load are ignored.
        bus.shift_dir   = DIR_RIGHT;
        bus.start_shift = 1'b1;
        tick();
        bus.start_shift = 1'b0;
        bus.shift_dir   = DIR_UP;
        check("t2_valid_low", bus.win_valid, 1'b0);
        check("t2_count0", bus.count, 0);
        check("t2_slid", bus.win_out, pack_win('{1, 2, 0, 4, 5, 0, 7, 8, 0}));
        send_pixel(8'd9);
        check("t2_valid_low1", bus.win_valid, 1'b0);
        send_pixel(8'd10);
        check("t2_no_done_early", bus.shift_done, 1'b0);
        send_pixel(8'd11);
        check("t2_shift_done", bus.shift_done, 1'b1);
        check("t2_win_valid", bus.win_valid, 1'b1);
        check("t2_count3", bus.count, 3);
        check("t2_window", bus.win_out, pack_win('{1, 2, 9, 4, 5, 10, 7, 8, 11}));
        tick();
        check("t2_done_pulse", bus.shift_done, 1'b0);

        // Test 3: the other three directions from a fresh fill.
        fill_window(0);
        do_shift(DIR_LEFT, 8'd9, 8'd10, 8'd11);
        check("t3_left_done", bus.shift_done, 1'b1);
        check("t3_left", bus.win_out, pack_win('{9, 0, 1, 10, 3, 4, 11, 6, 7}));
        fill_window(0);
        do_shift(DIR_DOWN, 8'd20, 8'd21, 8'd22);
        check("t3_down", bus.win_out, pack_win('{3, 4, 5, 6, 7, 8, 20, 21, 22}));
        fill_window(0);
        do_shift(DIR_UP, 8'd20, 8'd21, 8'd22);
        check("t3_up", bus.win_out, pack_win('{20, 21, 22, 0, 1, 2, 3, 4, 5}));

        // Test 4: fill with pix_valid alternating 1,0.
        bus.start_fill = 1'b1;
        tick();
        bus.start_fill = 1'b0;
        check("t4_valid_drop", bus.win_valid, 1'b0);
        for (int i = 0; i < N; i++) begin
            send_pixel(PIX_W'(i));
            check("t4_count_acc", bus.count, i + 1);
            check("t4_done_acc", bus.fill_done, (i == N - 1) ? 1'b1 : 1'b0);
            bus.pix_in = 8'hEE;
            tick();
            check("t4_count_idle", bus.count, i + 1);
        end
        check("t4_window", bus.win_out, pack_win('{0, 1, 2, 3, 4, 5, 6, 7, 8}));

        // Test 5: command errors.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.start_shift = 1'b1;
        tick();
        bus.start_shift = 1'b0;
        check("t5_idle_err", bus.cmd_err, 1'b1);
        check("t5_idle_ready", bus.pix_ready, 1'b0);
        tick();
        check("t5_err_pulse", bus.cmd_err, 1'b0);
        check("t5_still_idle", bus.pix_ready, 1'b0);
        fill_window(0);
        bus.start_fill  = 1'b1;
        bus.start_shift = 1'b1;
        tick();
        bus.start_fill  = 1'b0;
        bus.start_shift = 1'b0;
        check("t5_both_no_err", bus.cmd_err, 1'b0);
        check("t5_both_fill", bus.pix_ready, 1'b1);
        check("t5_both_no_slide", bus.win_out, pack_win('{0, 1, 2, 3, 4, 5, 6, 7, 8}));
        for (int i = 0; i < N; i++) send_pixel(PIX_W'(i));
        check("t5_refill_done", bus.fill_done, 1'b1);
        bus.shift_dir   = DIR_RIGHT;
        bus.start_shift = 1'b1;
        tick();
        bus.start_shift = 1'b0;
        send_pixel(8'd9);
        bus.start_fill = 1'b1;
        tick();
        bus.start_fill = 1'b0;
        check("t5_busy_err", bus.cmd_err, 1'b1);
        check("t5_busy_loading", bus.pix_ready, 1'b1);
        check("t5_busy_count", bus.count, 1);
        send_pixel(8'd10);
        send_pixel(8'd11);
        check("t5_shift_done", bus.shift_done, 1'b1);
        check("t5_window", bus.win_out, pack_win('{1, 2, 9, 4, 5, 10, 7, 8, 11}));

        // Test 6: abort mid-fill keeps written pixels; reset mid-load clears all.
        bus.start_fill = 1'b1;
        tick();
        bus.start_fill = 1'b0;
        for (int i = 0; i < 4; i++) send_pixel(PIX_W'(100 + i));
        check("t6_count4", bus.count, 4);
        bus.abort     = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_in    = 8'd104;
        tick();
        bus.abort     = 1'b0;
        bus.pix_valid = 1'b0;
        check("t6_abort_idle", bus.pix_ready, 1'b0);
        check("t6_abort_count", bus.count, 0);
        check("t6_abort_valid", bus.win_valid, 1'b0);
        check("t6_abort_window", bus.win_out, pack_win('{100, 101, 102, 103, 5, 10, 7, 8, 11}));
        fill_window(0);
        bus.shift_dir   = DIR_DOWN;
        bus.start_shift = 1'b1;
        tick();
        bus.start_shift = 1'b0;
        send_pixel(8'd20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_win", bus.win_out, '0);
        check("t6_rst_outs", {bus.win_valid, bus.pix_ready, bus.fill_done, bus.shift_done, bus.cmd_err}, 5'b00000);
        check("t6_rst_count", bus.count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/window_buffer_kxk.md
Name: window_buffer_kxk

Overview:
Parametrised successor to the fixed 3x3 Sobel window buffer. It holds a WIN x WIN pixel window of PIX_W-bit pixels and fills it from a serial valid/ready pixel stream. It slides the window one step in any of four directions, then loads only the WIN new pixels the slide requires. It sits between the pixel fetch/SRAM reader and the Sobel convolution datapath, which consumes win_out while win_valid is high.

Parameters:
PIX_W, 8, pixel width in bits
WIN, 3, window edge length; odd, >= 3
CNT_W, $clog2(WIN*WIN+1), width of the accepted-pixel counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
start_fill  in  1  request a full window load of WIN*WIN pixels
start_shift  in  1  request a one-step slide plus load of WIN pixels
shift_dir  in  2  00 right, 01 left, 10 down, 11 up; direction of window motion over the image
abort  in  1  cancel any load in progress
pix_in  in  PIX_W  incoming pixel
pix_valid  in  1  pix_in valid
pix_ready  out  1  block can accept a pixel
win_out  out  WIN*WIN*PIX_W  window, element i = r*WIN+c at bits [i*PIX_W +: PIX_W]; r0 = top row, c0 = left column
win_valid  out  1  window complete and stable
fill_done  out  1  one-cycle pulse when a fill completes
shift_done  out  1  one-cycle pulse when a shift load completes
cmd_err  out  1  one-cycle pulse when a command is rejected
count  out  CNT_W  pixels accepted in the current operation

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, all window elements 0, count 0, all outputs 0. Reset overrides every other input, including mid-operation.
- A pixel is accepted only when pix_valid && pix_ready. pix_ready = 1 only in FILL or LOAD, as a combinational function of state.
- States: IDLE, FILL, READY, LOAD.
- IDLE:
  - start_fill -> FILL, count 0.
  - start_shift alone -> cmd_err pulse next cycle; state stays IDLE.
- FILL:
  - Each accepted pixel is written to element index count (raster order), then count increments.
  - On the WIN*WIN-th accept, the next state is READY; fill_done and win_valid go high on the following cycle.
- READY:
  - win_valid = 1.
  - start_fill -> FILL; win_valid drops the next cycle; window contents are retained until overwritten.
  - start_shift -> slide at that edge, then LOAD with count 0 and win_valid 0.
  - If start_fill and start_shift are both high, fill wins and no cmd_err is raised.
- Slide, applied in a single cycle:
  - dir 00: columns move left (c <- c+1).
  - dir 01: columns move right (c <- c-1).
  - dir 10: rows move up (r <- r+1).
  - dir 11: rows move down (r <- r-1).
  - The vacated column or row is set to 0.
- LOAD:
  - Accepted pixels fill the vacated line in order.
  - A vacated column (dir 00/01) is filled top to bottom: dir 00 writes column WIN-1, dir 01 writes column 0.
  - A vacated row (dir 10/11) is filled left to right: dir 10 writes row WIN-1, dir 11 writes row 0.
  - shift_dir is latched at the start_shift edge; later changes are ignored.
  - After WIN accepts -> READY; shift_done and win_valid assert the next cycle.
- Busy rule: start_fill or start_shift seen in FILL or LOAD -> cmd_err pulse; the command is ignored.
- abort in FILL or LOAD:
  - State -> IDLE; count -> 0; win_valid stays 0.
  - Window contents are kept, not cleared.
  - A pixel presented in the same cycle is not accepted.
  - abort in IDLE or READY has no effect.
- count saturates at its terminal value; it never wraps within an operation.
- Latency: fill completes with fill_done exactly 1 cycle after the last accept; a shift completes with shift_done exactly 1 cycle after its WIN-th accept. Minimum shift duration is WIN+1 cycles.

Decomposition:
- Shared package window_pkg:
  - shift_dir_t enum (DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP).
  - wb_state_t enum (IDLE, FILL, READY, LOAD).
  - localparam function computing the write index from (dir, count, WIN).
- One natural sub-module: wb_line_index, combinational; maps latched direction and count to the target element index for LOAD and FILL writes.
- The window register array and slide logic stay in the top module.

Test Plan (WIN=3, PIX_W=8):
1. rst, start_fill, pixels 0..8 streamed back-to-back -> fill_done 1 cycle after the 9th accept; win_valid=1; win_out elements = {0,1,2,3,4,5,6,7,8}; count=9.
2. From test 1, start_shift dir 00 with pixels 9,10,11 -> win_valid=0 for 4 cycles, then shift_done; window = {1,2,9,4,5,10,7,8,11}.
3. From a fresh fill 0..8:
   - dir 01 with 9,10,11 -> {9,0,1,10,3,4,11,6,7}.
   - Refill 0..8, dir 10 with 20,21,22 -> {3,4,5,6,7,8,20,21,22}.
   - Refill 0..8, dir 11 with 20,21,22 -> {20,21,22,0,1,2,3,4,5}.
4. Backpressure: pix_valid toggled 1,0,1,0 during a fill -> count advances only on accepted cycles; final window identical to test 1; fill_done timing tracks the 9th accept.
5. start_shift in IDLE -> cmd_err pulse, state IDLE, pix_ready=0. start_fill while in LOAD -> cmd_err; shift still completes correctly.
6. Fill with 4 pixels accepted, then abort -> IDLE, count=0, elements 0..3 retained. rst mid-LOAD -> all elements 0 and all outputs 0 on the next cycle.
